wvl_cap_ctrl: RTL and testbench

WVL_CAP_CTRL -- requirements
Module: wvl_cap_ctrl

---
 rtl/wvl_cap_pkg.sv | 24 ++
 rtl/wvl_cap_ctrl.sv | 154 +++++++++++++++
 tb/tb_wvl_cap_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wvl_cap_pkg.sv
// Shared definitions for the capture controller: FSM encoding and the bit
// layout of the start_cap control word and the status word.
package wvl_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

  // start_cap_reg fields
  localparam int CFG_ARM_BIT     = 0;
  localparam int CFG_TRIG_EN_BIT = 1;
  localparam int CFG_LEN_LSB     = 16;

  // status_out fields
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_ABORT_BIT = 2;
  localparam int STAT_WAIT_BIT  = 3;
  localparam int STAT_CNT_LSB   = 16;

endpackage

// File: rtl/wvl_cap_ctrl.sv
// Software-armed capture controller: writes a run of valid samples into a
// block RAM, optionally starting on an external trigger.
module wvl_cap_ctrl
  import wvl_cap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       start_cap_reg,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              ext_trig,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [31:0]       status_out
);

  cap_state_e        state_q, state_d;
  logic              arm_q;
  logic              arm_vld_q;
  logic              trig_en_q, trig_en_d;
  logic [ADDR_W-1:0] len_m1_q, len_m1_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              arm_bit;
  logic              arm_edge;
  logic              accept;

  assign arm_bit = start_cap_reg[CFG_ARM_BIT];
  // arm_vld_q masks the first cycle after reset, so a bit0 already high at
  // release is not mistaken for a fresh 0->1 edge.
  assign arm_edge = arm_bit & ~arm_q & arm_vld_q;

  // Fields of the control word that this block never looks at.
  logic unused_cfg;
  assign unused_cfg = ^{start_cap_reg[31:CFG_LEN_LSB+ADDR_W],
                        start_cap_reg[CFG_LEN_LSB-1:CFG_TRIG_EN_BIT+1]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    trig_en_d = trig_en_q;
    len_m1_d  = len_m1_q;
    wr_cnt_d  = wr_cnt_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    accept    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm_edge) begin
          len_m1_d  = start_cap_reg[CFG_LEN_LSB +: ADDR_W];
          trig_en_d = start_cap_reg[CFG_TRIG_EN_BIT];
          wr_cnt_d  = '0;
          done_d    = 1'b0;
          aborted_d = 1'b0;
          state_d   = start_cap_reg[CFG_TRIG_EN_BIT] ? ST_WAIT_TRIG : ST_CAPTURE;
        end
      end
      ST_WAIT_TRIG: begin
        if (!arm_bit) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (ext_trig || !trig_en_q) begin
          // The sample that arrives with the trigger is the first one kept.
          state_d = ST_CAPTURE;
          accept  = din_valid;
        end
      end
      ST_CAPTURE: begin
        if (!arm_bit) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          accept = din_valid;
        end
      end
      ST_DONE: begin
        if (!arm_bit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      we_d     = 1'b1;
      addr_d   = wr_cnt_q[ADDR_W-1:0];
      wdata_d  = din;
      wr_cnt_d = wr_cnt_q + (ADDR_W+1)'(1);
      // The counter is one bit wider than the address, so a full buffer
      // reports 2^ADDR_W words without the address ever wrapping.
      if (wr_cnt_q[ADDR_W-1:0] == len_m1_q) begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q   <= ST_IDLE;
      arm_q     <= 1'b0;
      arm_vld_q <= 1'b0;
      trig_en_q <= 1'b0;
      len_m1_q  <= '0;
      wr_cnt_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the values
      // of the previous cycle, independent of statement order.
      state_q   <= state_d;
      arm_q     <= arm_bit;
      arm_vld_q <= 1'b1;
      trig_en_q <= trig_en_d;
      len_m1_q  <= len_m1_d;
      wr_cnt_q  <= wr_cnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_din  = wdata_q;

  always_comb begin
    status_out                                 = '0;
    status_out[STAT_BUSY_BIT]                  = (state_q == ST_WAIT_TRIG) ||
                                                 (state_q == ST_CAPTURE);
    status_out[STAT_DONE_BIT]                  = done_q;
    status_out[STAT_ABORT_BIT]                 = aborted_q;
    status_out[STAT_WAIT_BIT]                  = (state_q == ST_WAIT_TRIG);
    status_out[STAT_CNT_LSB +: ADDR_W+1]       = wr_cnt_q;
  end

endmodule

// File: tb/tb_wvl_cap_ctrl.sv
// Self-checking bench for wvl_cap_ctrl: the expected write list is the ordered
// list of samples the bench decides should be kept, numbered from address 0.
module tb_wvl_cap_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [31:0]       cyc;
  } wr_t;

  logic              user_clk = 1'b0;
  logic              user_rst_n;
  logic [31:0]       start_cap_reg;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              ext_trig;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [31:0]       status_out;

  wr_t exp_q[$];
  wr_t got_q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;

  wvl_cap_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .user_clk      (user_clk),
    .user_rst_n    (user_rst_n),
    .start_cap_reg (start_cap_reg),
    .din           (din),
    .din_valid     (din_valid),
    .ext_trig      (ext_trig),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .status_out    (status_out)
  );

  always #5 user_clk = ~user_clk;

  always @(posedge user_clk) cyc <= cyc + 1;

  // Every observed buffer write, tagged with the cycle it was visible in.
  always @(negedge user_clk)
    if (bram_we === 1'b1) got_q.push_back({bram_addr, bram_din, 32'(cyc)});

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic rand_v(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // One input cycle. A kept sample must appear as a write one cycle later at
  // the next free address.
  task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] d,
                             input logic t, input bit keep);
    din_valid = v;
    din       = d;
    ext_trig  = t;
    if (keep) exp_q.push_back({ADDR_W'(exp_q.size()), d, 32'(cyc + 1)});
    @(negedge user_clk);
  endtask

  task automatic set_reg(input bit a, input bit t, input int len);
    start_cap_reg = (32'(len) << 16) | (32'(t) << 1) | 32'(a);
  endtask

  // Drop bit0 for a cycle, then raise it; the arming cycle's sample is never kept.
  task automatic arm(input int len, input bit t);
    set_reg(1'b0, t, len);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    exp_q.delete();
    got_q.delete();
    set_reg(1'b1, t, len);
    drive_cycle(rand_v(50), $urandom, 1'b0, 1'b0);
  endtask

  task automatic trail(input int n, input int pct);
    for (int i = 0; i < n; i++) drive_cycle(rand_v(pct), $urandom, 1'($urandom), 1'b0);
  endtask

  // Random stream that keeps exactly n samples, then idles with more traffic.
  task automatic run_stream(input int n, input int pct, input bit t, input int twait);
    int   acc = 0;
    logic v;
    if (t) begin
      for (int i = 0; i < twait; i++) drive_cycle(rand_v(pct), $urandom, 1'b0, 1'b0);
      v = rand_v(pct);
      drive_cycle(v, $urandom, 1'b1, v);
      acc += int'(v);
    end
    for (int g = 0; g < 20000 && acc < n; g++) begin
      v = rand_v(pct);
      drive_cycle(v, $urandom, 1'($urandom), v);
      acc += int'(v);
    end
    trail(3, pct);
  endtask

  task automatic test_reset();
    user_rst_n    = 1'b0;
    start_cap_reg = '0;
    din           = '0;
    din_valid     = 1'b0;
    ext_trig      = 1'b0;
    repeat (3) @(negedge user_clk);
    total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", bram_we); end
    total++; if (bram_addr !== '0) begin bad++; $display("FAIL rst_addr got=%h want=0", bram_addr); end
    total++; if (bram_din !== '0) begin bad++; $display("FAIL rst_din got=%h want=0", bram_din); end
    total++; if (status_out !== '0) begin bad++; $display("FAIL rst_status got=%h want=0", status_out); end
    // bit0 already high when reset lifts must not start a capture.
    set_reg(1'b1, 1'b0, 3);
    user_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rst_noarm_writes got=%0d want=0", got_q.size()); end
    total++; if (status_out !== '0) begin bad++; $display("FAIL rst_noarm_status got=%h want=0", status_out); end
  endtask

  task automatic test_immediate();
    arm(3, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, DATA_W'(32'hA0 + i), 1'b0, 1'b1);
    for (int i = 4; i < 7; i++) drive_cycle(1'b1, DATA_W'(32'hA0 + i), 1'b0, 1'b0);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL imm_nwr got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL imm_wr[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (status_out !== 32'h0004_0002) begin bad++; $display("FAIL imm_status got=%h want=00040002", status_out); end
    set_reg(1'b0, 1'b0, 3);
    drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    total++; if (status_out !== 32'h0004_0002) begin bad++; $display("FAIL imm_hold_status got=%h want=00040002", status_out); end
  endtask

  task automatic test_triggered();
    arm(1, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(rand_v(70), $urandom, 1'b0, 1'b0);
    total++; if (status_out !== 32'h0000_0009) begin bad++; $display("FAIL trig_wait_status got=%h want=00000009", status_out); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL trig_wait_writes got=%0d want=0", got_q.size()); end
    drive_cycle(1'b1, DATA_W'(32'h55), 1'b1, 1'b1);
    drive_cycle(1'b1, DATA_W'(32'h66), 1'b0, 1'b1);
    trail(4, 80);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL trig_nwr got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL trig_wr[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (status_out !== 32'h0002_0002) begin bad++; $display("FAIL trig_status got=%h want=00020002", status_out); end
  endtask

  task automatic test_gapped();
    int   acc = 0;
    logic v;
    arm(2, 1'b0);
    for (int i = 0; acc < 3; i++) begin
      v = (i % 3 == 2);
      drive_cycle(v, $urandom, 1'b0, v);
      acc += int'(v);
    end
    for (int i = 0; i < 6; i++) drive_cycle(i % 3 == 2, $urandom, 1'b0, 1'b0);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL gap_nwr got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL gap_wr[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (status_out !== 32'h0003_0002) begin bad++; $display("FAIL gap_status got=%h want=00030002", status_out); end
  endtask

  task automatic test_abort();
    arm(9, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b1);
    set_reg(1'b0, 1'b0, 9);
    drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    trail(4, 100);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL abort_nwr got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_wr[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (status_out !== 32'h0005_0004) begin bad++; $display("FAIL abort_status got=%h want=00050004", status_out); end
  endtask

  task automatic test_full();
    arm(1023, 1'b0);
    run_stream(1024, 70, 1'b0, 0);
    trail(5, 100);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL full_nwr got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_wr[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) begin
      total++;
      if (got_q[got_q.size()-1].addr !== 10'h3FF) begin bad++; $display("FAIL full_last_addr got=%h want=3ff", got_q[got_q.size()-1].addr); end
    end
    total++; if (status_out !== 32'h0400_0002) begin bad++; $display("FAIL full_status got=%h want=04000002", status_out); end
  endtask

  task automatic test_random();
    int          len;
    bit          t;
    logic [31:0] want;
    for (int r = 0; r < 8; r++) begin
      len = (r == 0) ? 0 : int'($urandom_range(0, 20));
      t   = (r == 1) ? 1'b1 : 1'($urandom);
      arm(len, t);
      run_stream(len + 1, int'($urandom_range(20, 100)), t, int'($urandom_range(0, 5)));
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_nwr got=%0d want=%0d", r, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_wr[%0d] got=%h want=%h", r, i, got_q[i], exp_q[i]); end
      end
      want = (32'(len + 1) << 16) | 32'h2;
      total++; if (status_out !== want) begin bad++; $display("FAIL rnd%0d_status got=%h want=%h", r, status_out, want); end
    end
  endtask

  task automatic test_reset_rearm();
    arm(9, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b1);
    #2 user_rst_n = 1'b0;
    #1;
    total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL rearm_async_we got=%b want=0", bram_we); end
    total++; if (status_out !== '0) begin bad++; $display("FAIL rearm_async_status got=%h want=0", status_out); end
    got_q.delete();
    exp_q.delete();
    @(negedge user_clk);
    user_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rearm_held_writes got=%0d want=0", got_q.size()); end
    total++; if (status_out !== '0) begin bad++; $display("FAIL rearm_held_status got=%h want=0", status_out); end
    arm(1, 1'b0);
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b1);
    trail(3, 100);
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rearm_nwr got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rearm_wr[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (status_out !== 32'h0002_0002) begin bad++; $display("FAIL rearm_status got=%h want=00020002", status_out); end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_triggered();
    test_gapped();
    test_abort();
    test_full();
    test_random();
    test_reset_rearm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
